// File: rtl/quad_gen_pkg.sv
// Shared types and Gray-code tables for the quadrature/switch stimulus generator.
package quad_gen_pkg;

  typedef enum logic [1:0] {IDLE, EDGE, HOLD} quad_state_e;
  typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_PRESS} sw_state_e;

  // (a,b) pairs indexed by phase, phase 0 at [1:0]; every step walks phase 1,2,3,0
  localparam logic [7:0] GRAY_CW  = {2'b01, 2'b11, 2'b10, 2'b00};
  localparam logic [7:0] GRAY_CCW = {2'b10, 2'b11, 2'b01, 2'b00};

  function automatic logic [1:0] gray_ab(input logic cw, input logic [1:0] ph);
    return cw ? GRAY_CW[{ph, 1'b0} +: 2] : GRAY_CCW[{ph, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/quad_sw_gen.sv
// Switch press generator: optional bounce toggles followed by a stable press.
module quad_sw_gen
  import quad_gen_pkg::*;
#(
  parameter int PRESS_CYCLES  = 50,
  parameter int BOUNCE_EDGES  = 0,
  parameter int BOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_req,
  output logic sw,
  output logic sw_busy
);

  localparam int MAX_C = (PRESS_CYCLES > BOUNCE_CYCLES) ? PRESS_CYCLES : BOUNCE_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int TOG_W = $clog2(BOUNCE_EDGES + 2);
  localparam logic [CNT_W-1:0] PRESS_RELOAD  = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_RELOAD = CNT_W'(BOUNCE_CYCLES - 1);

  sw_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TOG_W-1:0] tog_q, tog_d;
  logic             sw_q, sw_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tog_d   = tog_q;
    sw_d    = sw_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: if (sw_req) begin
        sw_d   = 1'b1;
        busy_d = 1'b1;
        if (BOUNCE_EDGES > 0) begin
          state_d = S_BOUNCE;
          cnt_d   = BOUNCE_RELOAD;
          tog_d   = TOG_W'(BOUNCE_EDGES);
        end else begin
          state_d = S_PRESS;
          cnt_d   = PRESS_RELOAD;
        end
      end
      // even toggle count leaves sw high when the last bounce lands
      S_BOUNCE: if (cnt_q == '0) begin
        sw_d = ~sw_q;
        if (tog_q == TOG_W'(1)) begin
          state_d = S_PRESS;
          cnt_d   = PRESS_RELOAD;
        end else begin
          tog_d = tog_q - 1'b1;
          cnt_d = BOUNCE_RELOAD;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      S_PRESS: if (cnt_q == '0) begin
        state_d = S_IDLE;
        sw_d    = 1'b0;
        busy_d  = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tog_q   <= '0;
      sw_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      sw_q    <= sw_d;
      busy_q  <= busy_d;
    end
  end

  assign sw      = sw_q;
  assign sw_busy = busy_q;

endmodule

// File: rtl/quad_gen.sv
// Quadrature encoder stimulus generator: step commands become ina/inb detents,
// press commands become an optionally bouncing sw line.
module quad_gen
  import quad_gen_pkg::*;
#(
  parameter int EDGE_CYCLES   = 5,
  parameter int PRESS_CYCLES  = 50,
  parameter int BOUNCE_EDGES  = 0,
  parameter int BOUNCE_CYCLES = 2,
  parameter int POS_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_valid,
  input  logic             step_dir,
  output logic             step_ready,
  input  logic             sw_req,
  output logic             sw_busy,
  output logic             ina,
  output logic             inb,
  output logic             sw,
  output logic [POS_W-1:0] pos
);

  localparam int CNT_W = (EDGE_CYCLES > 1) ? $clog2(EDGE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] EDGE_RELOAD = CNT_W'(EDGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(EDGE_CYCLES - 2);

  quad_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       edges_q, edges_d;
  logic [1:0]       phase_q, phase_d;
  logic             dir_q, dir_d;
  logic             ina_q, ina_d, inb_q, inb_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             ready_q, ready_d;
  logic             fire, fire_dir;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    edges_d  = edges_q;
    phase_d  = phase_q;
    dir_d    = dir_q;
    ina_d    = ina_q;
    inb_d    = inb_q;
    pos_d    = pos_q;
    ready_d  = ready_q;
    fire     = 1'b0;
    fire_dir = dir_q;
    case (state_q)
      IDLE: if (step_valid && ready_q) begin
        fire     = 1'b1;
        fire_dir = step_dir;
        dir_d    = step_dir;
        cnt_d    = EDGE_RELOAD;
        edges_d  = 2'd3;
        ready_d  = 1'b0;
        state_d  = EDGE;
      end
      EDGE: if (cnt_q == '0) begin
        fire = 1'b1;
        if (edges_q == 2'd1) begin
          pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          edges_d = 2'd0;
          // HOLD is E-1 cycles long, so with E=1 it vanishes entirely
          if (EDGE_CYCLES == 1) begin
            state_d = IDLE;
            ready_d = 1'b1;
          end else begin
            state_d = HOLD;
            cnt_d   = HOLD_RELOAD;
          end
        end else begin
          edges_d = edges_q - 2'd1;
          cnt_d   = EDGE_RELOAD;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      HOLD: if (cnt_q == '0) begin
        state_d = IDLE;
        ready_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (fire) begin
      phase_d        = phase_q + 2'd1;
      {ina_d, inb_d} = gray_ab(fire_dir, phase_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      edges_q <= '0;
      phase_q <= '0;
      dir_q   <= 1'b0;
      ina_q   <= 1'b0;
      inb_q   <= 1'b0;
      pos_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edges_q <= edges_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      ina_q   <= ina_d;
      inb_q   <= inb_d;
      pos_q   <= pos_d;
      ready_q <= ready_d;
    end
  end

  quad_sw_gen #(
    .PRESS_CYCLES (PRESS_CYCLES),
    .BOUNCE_EDGES (BOUNCE_EDGES),
    .BOUNCE_CYCLES(BOUNCE_CYCLES)
  ) u_sw (
    .clk    (clk),
    .rst    (rst),
    .sw_req (sw_req),
    .sw     (sw),
    .sw_busy(sw_busy)
  );

  assign ina        = ina_q;
  assign inb        = inb_q;
  assign pos        = pos_q;
  assign step_ready = ready_q;

endmodule

// File: tb/tb_quad_gen.sv
// Bench for quad_gen: two instances (E=5 with bounce, E=1 with narrow pos)
// checked every cycle against a time-based model, plus directed literal checks.
module tb_quad_gen;

  localparam int E_P[2]  = '{5, 1};
  localparam int B_P[2]  = '{4, 0};
  localparam int C_P[2]  = '{2, 1};
  localparam int P_P[2]  = '{10, 3};
  localparam int MASK[2] = '{'hFFFF, 'hF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  sv, sd, sq, rdy, busy, a, b, sw;
  logic [15:0] pos5;
  logic [3:0]  pos1;

  quad_gen #(.EDGE_CYCLES(5), .PRESS_CYCLES(10), .BOUNCE_EDGES(4), .BOUNCE_CYCLES(2), .POS_W(16)) u_q5 (
    .clk(clk), .rst(rst), .step_valid(sv[0]), .step_dir(sd[0]), .step_ready(rdy[0]),
    .sw_req(sq[0]), .sw_busy(busy[0]), .ina(a[0]), .inb(b[0]), .sw(sw[0]), .pos(pos5));

  quad_gen #(.EDGE_CYCLES(1), .PRESS_CYCLES(3), .BOUNCE_EDGES(0), .BOUNCE_CYCLES(1), .POS_W(4)) u_q1 (
    .clk(clk), .rst(rst), .step_valid(sv[1]), .step_dir(sd[1]), .step_ready(rdy[1]),
    .sw_req(sq[1]), .sw_busy(busy[1]), .ina(a[1]), .inb(b[1]), .sw(sw[1]), .pos(pos1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // inputs as the DUT saw them at the last rising edge
  logic       rst_s = 1'b0;
  logic [1:0] sv_s = '0, sd_s = '0, sq_s = '0;
  int         cyc_s = 0;
  always @(posedge clk) begin
    cyc_s <= cyc_s + 1;
    rst_s <= rst;
    sv_s  <= sv;
    sd_s  <= sd;
    sq_s  <= sq;
  end

  function automatic logic [1:0] gray(input bit cw, input int e);
    case (e % 4)
      0:       return 2'b00;
      1:       return cw ? 2'b10 : 2'b01;
      2:       return 2'b11;
      default: return cw ? 2'b01 : 2'b10;
    endcase
  endfunction

  // model: each step/press is a start time; outputs are a function of elapsed cycles
  bit         mok = 0;
  bit         act[2], dr[2], sact[2];
  int         st[2], ss[2], pm[2];
  logic [1:0] prev_ab[2];

  initial begin
    int n, k, e, xpos, xrdy, xsw, xbusy, bc, got_pos;
    bit rb, bb;
    logic [1:0] xab, gab;
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; sact[i] = 0; pm[i] = 0; st[i] = 0; ss[i] = 0; dr[i] = 0; prev_ab[i] = 2'b00;
    end
    forever begin
      @(negedge clk);
      n = cyc_s;
      for (int i = 0; i < 2; i++) begin
        bc = B_P[i] * C_P[i];
        if (rst_s) begin
          act[i] = 0; sact[i] = 0; pm[i] = 0;
        end else begin
          rb = !act[i] || (n - 1 - st[i] >= 4 * E_P[i] - 1);
          if (act[i] && rb) begin
            pm[i] = pm[i] + (dr[i] ? 1 : -1);
            act[i] = 0;
          end
          if (sv_s[i] && rb) begin
            act[i] = 1; st[i] = n; dr[i] = sd_s[i];
          end
          bb = sact[i] && (n - 1 - ss[i] < bc + P_P[i]);
          if (sq_s[i] && !bb) begin
            sact[i] = 1; ss[i] = n;
          end
        end
        if (act[i]) begin
          k    = n - st[i];
          e    = (k >= 3 * E_P[i]) ? 4 : k / E_P[i] + 1;
          xab  = gray(dr[i], e);
          xpos = pm[i] + ((k >= 3 * E_P[i]) ? (dr[i] ? 1 : -1) : 0);
          xrdy = (k >= 4 * E_P[i] - 1) ? 1 : 0;
        end else begin
          xab = 2'b00; xpos = pm[i]; xrdy = 1;
        end
        k = n - ss[i];
        if (sact[i] && k < bc + P_P[i]) begin
          xbusy = 1;
          xsw   = (k < bc) ? (((k / C_P[i]) % 2 == 0) ? 1 : 0) : 1;
        end else begin
          xbusy = 0; xsw = 0;
        end
        gab     = {a[i], b[i]};
        got_pos = (i == 0) ? int'(pos5) : int'(pos1);
        if (mok || rst_s) begin
          chk($sformatf("ab%0d", i),   gab, xab);
          chk($sformatf("pos%0d", i),  got_pos, xpos & MASK[i]);
          chk($sformatf("rdy%0d", i),  rdy[i], xrdy);
          chk($sformatf("sw%0d", i),   sw[i], xsw);
          chk($sformatf("busy%0d", i), busy[i], xbusy);
          if (mok && !rst_s)
            chk($sformatf("onetoggle%0d", i), ($countones(gab ^ prev_ab[i]) <= 1) ? 1 : 0, 1);
        end
        prev_ab[i] = gab;
      end
      if (rst_s) mok = 1;
    end
  end

  task automatic step5(input bit dir, input logic [7:0] seq, input int epos);
    int lows;
    lows = 0;
    sv[0] = 1'b1; sd[0] = dir;
    tick();
    sv[0] = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (j > 0) tick();
      if (j % 5 == 0) chk("dir_ab", {a[0], b[0]}, seq[7 - 2 * (j / 5) -: 2]);
      if (!rdy[0]) lows++;
    end
    chk("dir_pos", pos5, epos);
    // low from the accepting edge up to t+4E-1, so a held valid is taken at t+4E
    chk("dir_rdy_low", lows, 19);
    chk("dir_rdy_back", rdy[0], 1);
  endtask

  initial begin
    logic [19:0] swv, bzv;
    logic [1:0]  pv;
    int          tg;
    rst = 1'b1; sv = '0; sd = '0; sq = '0;
    tick(); tick();
    chk("rst_ab", {a, b}, 0);
    chk("rst_pos", pos5, 0);
    chk("rst_rdy", rdy, 3);
    chk("rst_busy", busy, 0);
    chk("rst_sw", sw, 0);
    rst = 1'b0;
    tick();

    step5(1'b1, 8'b10_11_01_00, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    step5(1'b0, 8'b01_11_10_00, 'hFFFF);

    // press and step on the same cycle; a second press mid-press is dropped
    sq[0] = 1'b1; sv[0] = 1'b1; sd[0] = 1'b1;
    tick();
    sq[0] = 1'b0; sv[0] = 1'b0;
    swv = '0; bzv = '0;
    for (int j = 0; j < 20; j++) begin
      if (j > 0) tick();
      swv[j] = sw[0];
      bzv[j] = busy[0];
      sq[0]  = (j == 10);
    end
    chk("press_sw", swv, 'h3FF33);
    chk("press_busy", bzv, 'h3FFFF);

    // reset landing on edge 2 of a step
    rst = 1'b1; tick(); rst = 1'b0;
    sv[0] = 1'b1; sd[0] = 1'b1;
    tick();
    sv[0] = 1'b0;
    repeat (4) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_ab", {a[0], b[0]}, 0);
    chk("abort_pos", pos5, 0);
    chk("abort_rdy", rdy[0], 1);

    // E=1, valid held for three steps while dir wiggles between accepts
    rst = 1'b1; tick(); rst = 1'b0;
    sv[1] = 1'b1;
    pv = {a[1], b[1]};
    tg = 0;
    for (int j = 0; j < 12; j++) begin
      sd[1] = (j % 4 == 0);
      tick();
      tg += $countones({a[1], b[1]} ^ pv);
      pv = {a[1], b[1]};
    end
    sv[1] = 1'b0;
    chk("e1_toggles", tg, 12);
    chk("e1_pos", pos1, 3);
    chk("e1_ab", {a[1], b[1]}, 0);

    // signed wrap of a 4-bit position: 7 -> 8
    rst = 1'b1; tick(); rst = 1'b0;
    sv[1] = 1'b1; sd[1] = 1'b1;
    repeat (28) tick();
    chk("wrap_pre", pos1, 7);
    repeat (4) tick();
    sv[1] = 1'b0;
    chk("wrap_post", pos1, 8);

    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(499) == 0);
      for (int i = 0; i < 2; i++) begin
        sv[i] = ((c / 500) % 2 == 1) ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
        sd[i] = 1'($urandom);
        sq[i] = ($urandom_range(19) == 0);
      end
      tick();
    end
    rst = 1'b0; sv = '0; sq = '0;
    repeat (40) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
